hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_decoder_pkg.sv | 10 +
 rtl/hamming_parity_gen.sv | 15 +
 rtl/hamming_decoder.sv | 119 +++++++++++
 tb/tb_hamming_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_decoder_pkg.sv
// Shared Hamming(12,8) definitions used by the encoder and the decoder.
package hamming_decoder_pkg;

    localparam int PATTERN_WIDTH = 8;
    localparam int PARITY_WIDTH  = 4;

    typedef logic [PATTERN_WIDTH-1:0] pattern_t;
    typedef logic [PARITY_WIDTH-1:0]  parity_t;

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming(12,8) parity generator shared by encode and decode paths.
module hamming_parity_gen
    import hamming_decoder_pkg::*;
(
    input  pattern_t pattern,
    output parity_t  parity
);

    // Data d0..d7 sit at positions 3,5,6,7,9,10,11,12; parity i covers positions with bit i set.
    assign parity[0] = pattern[0] ^ pattern[1] ^ pattern[3] ^ pattern[4] ^ pattern[6];
    assign parity[1] = pattern[0] ^ pattern[2] ^ pattern[3] ^ pattern[5] ^ pattern[6];
    assign parity[2] = pattern[1] ^ pattern[2] ^ pattern[3] ^ pattern[7];
    assign parity[3] = pattern[4] ^ pattern[5] ^ pattern[6] ^ pattern[7];

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(12,8) decoder with valid/ready handshake and saturating error counters.
module hamming_decoder
    import hamming_decoder_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  pattern_t             i_pattern,
    input  parity_t              i_parity,
    output logic                 o_valid,
    input  logic                 i_ready,
    output pattern_t             o_pattern,
    output parity_t              o_syndrome,
    output logic                 o_err_corr,
    output logic                 o_err_uncorr,
    input  logic                 i_cnt_clr,
    output logic [CNT_WIDTH-1:0] o_corr_cnt,
    output logic [CNT_WIDTH-1:0] o_uncorr_cnt
);

    function automatic pattern_t correct_data(input pattern_t data, input parity_t syn);
        pattern_t flip;
        case (syn)
            4'd3:    flip = 8'h01;
            4'd5:    flip = 8'h02;
            4'd6:    flip = 8'h04;
            4'd7:    flip = 8'h08;
            4'd9:    flip = 8'h10;
            4'd10:   flip = 8'h20;
            4'd11:   flip = 8'h40;
            4'd12:   flip = 8'h80;
            default: flip = 8'h00;
        endcase
        return data ^ flip;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        return (&cnt) ? cnt : cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    parity_t               calc_parity;
    logic                  vld_p1;
    pattern_t              pattern_p1;
    parity_t               syndrome_p1;
    logic                  vld_p2;
    pattern_t              pattern_p2;
    parity_t               syndrome_p2;
    logic                  corr_p2;
    logic                  uncorr_p2;
    logic                  adv_p2;
    logic                  xfer_out;
    logic [CNT_WIDTH-1:0]  corr_cnt;
    logic [CNT_WIDTH-1:0]  uncorr_cnt;

    hamming_parity_gen u_parity_gen (
        .pattern (i_pattern),
        .parity  (calc_parity)
    );

    assign adv_p2   = !vld_p2 || i_ready;
    assign o_ready  = !vld_p1 || adv_p2;
    assign xfer_out = vld_p2 && i_ready;

    // Stage 1: capture received data and its syndrome
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1      <= 1'b0;
            pattern_p1  <= '0;
            syndrome_p1 <= '0;
        end else if (o_ready) begin
            vld_p1      <= i_valid;
            pattern_p1  <= i_pattern;
            syndrome_p1 <= calc_parity ^ i_parity;
        end
    end

    // Stage 2: corrected data and error classification
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p2      <= 1'b0;
            pattern_p2  <= '0;
            syndrome_p2 <= '0;
            corr_p2     <= 1'b0;
            uncorr_p2   <= 1'b0;
        end else if (adv_p2) begin
            vld_p2      <= vld_p1;
            pattern_p2  <= correct_data(pattern_p1, syndrome_p1);
            syndrome_p2 <= syndrome_p1;
            corr_p2     <= (syndrome_p1 != 4'd0) && (syndrome_p1 <= 4'd12);
            uncorr_p2   <= (syndrome_p1 >= 4'd13);
        end
    end

    // Counters: clear wins over a same-cycle increment
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (i_cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (xfer_out) begin
            if (corr_p2)   corr_cnt   <= sat_inc(corr_cnt);
            if (uncorr_p2) uncorr_cnt <= sat_inc(uncorr_cnt);
        end
    end

    assign o_valid      = vld_p2;
    assign o_pattern    = pattern_p2;
    assign o_syndrome   = syndrome_p2;
    assign o_err_corr   = corr_p2;
    assign o_err_uncorr = uncorr_p2;
    assign o_corr_cnt   = corr_cnt;
    assign o_uncorr_cnt = uncorr_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: codeword-level reference model plus directed and random traffic.
module tb_hamming_decoder;
    import hamming_decoder_pkg::*;

    localparam int CNT_WIDTH = 16;
    localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    localparam int LIT_SYN [4] = '{0, 6, 4, 15};
    localparam int LIT_CORR[4] = '{0, 1, 1, 0};
    localparam int LIT_UNC [4] = '{0, 0, 0, 1};
    localparam int LIT_CC  [4] = '{0, 1, 2, 2};
    localparam int LIT_UC  [4] = '{0, 0, 0, 1};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_valid, o_ready, o_valid, i_ready;
    pattern_t             i_pattern, o_pattern;
    parity_t              i_parity, o_syndrome;
    logic                 o_err_corr, o_err_uncorr, i_cnt_clr;
    logic [CNT_WIDTH-1:0] o_corr_cnt, o_uncorr_cnt;

    always #5 clk = ~clk;

    hamming_decoder #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_pattern    (i_pattern),
        .i_parity     (i_parity),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pattern    (o_pattern),
        .o_syndrome   (o_syndrome),
        .o_err_corr   (o_err_corr),
        .o_err_uncorr (o_err_uncorr),
        .i_cnt_clr    (i_cnt_clr),
        .o_corr_cnt   (o_corr_cnt),
        .o_uncorr_cnt (o_uncorr_cnt)
    );

    typedef struct {
        int         tag;
        logic [7:0] pat;
        logic [3:0] syn;
        logic       corr;
        logic       unc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_idx = 0;
    int lit_pending = -1;
    int sat_seen = 0;
    int to_seen = 0;
    int sat_events = 0;
    int drv_timeouts = 0;
    logic [CNT_WIDTH-1:0] mc = '0;
    logic [CNT_WIDTH-1:0] mu = '0;

    // Reference: syndrome is the XOR of the positions of all set codeword bits.
    function automatic exp_t model(input logic [7:0] pat, input logic [3:0] par);
        exp_t e;
        logic [12:0] cw;
        logic [3:0] syn;
        cw = '0;
        for (int i = 0; i < 8; i++) cw[DPOS[i]] = pat[i];
        for (int i = 0; i < 4; i++) cw[1 << i] = par[i];
        syn = '0;
        for (int p = 1; p <= 12; p++) if (cw[p]) syn = syn ^ 4'(p);
        if (syn >= 4'd1 && syn <= 4'd12) cw[syn] = ~cw[syn];
        for (int i = 0; i < 8; i++) e.pat[i] = cw[DPOS[i]];
        e.tag  = 0;
        e.syn  = syn;
        e.corr = (syn != 4'd0) && (syn <= 4'd12);
        e.unc  = (syn > 4'd12);
        return e;
    endfunction

    // Encode data into a codeword, then flip nflip random positions; returns {parity, pattern}.
    function automatic logic [11:0] make_word(input logic [7:0] d, input int nflip);
        logic [12:0] cw;
        logic [7:0]  pat;
        logic [3:0]  par;
        logic        p;
        int          pos;
        cw = '0;
        for (int i = 0; i < 8; i++) cw[DPOS[i]] = d[i];
        for (int i = 0; i < 4; i++) begin
            p = 1'b0;
            for (int k = 1; k <= 12; k++)
                if (((k >> i) & 1) == 1 && k != (1 << i)) p = p ^ cw[k];
            cw[1 << i] = p;
        end
        for (int f = 0; f < nflip; f++) begin
            pos = int'($urandom_range(1, 12));
            cw[pos] = ~cw[pos];
        end
        for (int i = 0; i < 8; i++) pat[i] = cw[DPOS[i]];
        for (int i = 0; i < 4; i++) par[i] = cw[1 << i];
        return {par, pat};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic hv;
        cyc++;
        if (sat_events != sat_seen) begin
            sat_seen = sat_events;
            mc = '1;
        end
        if (drv_timeouts != to_seen) begin
            to_seen = drv_timeouts;
            chk("driver_timeout", 32'd1, 32'd0);
        end
        if (rst) begin
            q.delete();
            mc = '0;
            mu = '0;
            lit_pending = -1;
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_pattern", 32'(o_pattern), 32'd0);
            chk("rst_syndrome", 32'(o_syndrome), 32'd0);
            chk("rst_flags", 32'({o_err_corr, o_err_uncorr}), 32'd0);
            chk("rst_counters", {o_corr_cnt, o_uncorr_cnt}, 32'd0);
        end else begin
            chk("corr_cnt", 32'(o_corr_cnt), 32'(mc));
            chk("uncorr_cnt", 32'(o_uncorr_cnt), 32'(mu));
            if (lit_pending >= 0) begin
                chk("lit_corr_cnt", 32'(o_corr_cnt), 32'(LIT_CC[lit_pending]));
                chk("lit_uncorr_cnt", 32'(o_uncorr_cnt), 32'(LIT_UC[lit_pending]));
                lit_pending = -1;
            end
            chk("o_ready", 32'(o_ready), 32'((q.size() < 2) || i_ready));
            hv = (q.size() > 0) && (q[0].tag + 1 <= cyc);
            chk("o_valid", 32'(o_valid), 32'(hv));
            if (hv) begin
                e = q[0];
                chk("o_pattern", 32'(o_pattern), 32'(e.pat));
                chk("o_syndrome", 32'(o_syndrome), 32'(e.syn));
                chk("o_err_corr", 32'(o_err_corr), 32'(e.corr));
                chk("o_err_uncorr", 32'(o_err_uncorr), 32'(e.unc));
                if (i_ready) begin
                    if (out_idx < 4) begin
                        chk("lit_pattern", 32'(o_pattern), 32'h0000_00A5);
                        chk("lit_syndrome", 32'(o_syndrome), 32'(LIT_SYN[out_idx]));
                        chk("lit_err_corr", 32'(o_err_corr), 32'(LIT_CORR[out_idx]));
                        chk("lit_err_uncorr", 32'(o_err_uncorr), 32'(LIT_UNC[out_idx]));
                        lit_pending = out_idx;
                    end
                    out_idx++;
                    if (e.corr && !(&mc)) mc = mc + 1'b1;
                    if (e.unc && !(&mu)) mu = mu + 1'b1;
                    void'(q.pop_front());
                end
            end
            if (i_cnt_clr) begin
                mc = '0;
                mu = '0;
            end
            if (i_valid && o_ready) begin
                e = model(i_pattern, i_parity);
                e.tag = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] pat, input logic [3:0] par);
        int c;
        logic done;
        c = 0;
        done = 1'b0;
        i_valid = 1'b1;
        i_pattern = pat;
        i_parity = par;
        while (!done && c < 50) begin
            @(negedge clk);
            done = o_ready;
            step();
            c++;
        end
        if (!done) drv_timeouts++;
        i_valid = 1'b0;
    endtask

    task automatic burst3();
        logic [11:0] w[3];
        int sent, c;
        w[0] = make_word(8'h3C, 0);
        w[1] = make_word(8'hC3, 1);
        w[2] = make_word(8'h0F, 1);
        sent = 0;
        c = 0;
        while (sent < 3 && c < 50) begin
            i_ready = (c >= 5);
            i_valid = 1'b1;
            {i_parity, i_pattern} = w[sent];
            @(negedge clk);
            if (o_ready) sent++;
            step();
            c++;
        end
        if (sent < 3) drv_timeouts++;
        i_valid = 1'b0;
        i_ready = 1'b1;
    endtask

    initial begin
        logic [11:0] w;
        rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_pattern = '0;
        i_parity = '0;
        i_cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(8'hA5, 4'b0011);
        send(8'hA1, 4'b0011);
        send(8'hA5, 4'b0111);
        send(8'hA5, 4'b1100);
        repeat (4) step();

        burst3();
        repeat (4) step();

        force dut.corr_cnt = '1;
        sat_events++;
        step();
        release dut.corr_cnt;
        step();
        send(8'hA1, 4'b0011);
        repeat (4) step();

        i_cnt_clr = 1'b1;
        send(8'hA1, 4'b0011);
        step();
        step();
        i_cnt_clr = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 3; i++) begin
            w = make_word(8'($urandom), 1);
            i_valid = 1'b1;
            {i_parity, i_pattern} = w;
            step();
        end
        i_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();

        for (int n = 0; n < 3000; n++) begin
            w = make_word(8'($urandom), int'($urandom_range(0, 2)));
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_cnt_clr = ($urandom_range(0, 63) == 0);
            {i_parity, i_pattern} = w;
            rst = (n == 1500);
            step();
        end
        rst = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_cnt_clr = 1'b0;
        repeat (6) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
